// File: rtl/banked_memory_wrapper.sv
// Banked single-port memory: MEM_NUMBER lanes share one address,
// with per-lane write enables, registered read and an init sweep.
module banked_memory_wrapper #(
  parameter int                WIDTH          = 8,
  parameter int                DEPTH          = 128,
  parameter int                ADDR_WIDTH     = 7,
  parameter int                MEM_NUMBER     = 4,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [WIDTH-1:0]  INIT_VALUE     = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic [WIDTH*MEM_NUMBER-1:0] wdata,
  input  logic                        wr_en,
  input  logic [MEM_NUMBER-1:0]       lane_en,
  input  logic                        rd_en,
  output logic [WIDTH*MEM_NUMBER-1:0] rdata,
  output logic                        rd_valid,
  output logic                        ready,
  output logic                        err
);

  localparam int DW = WIDTH * MEM_NUMBER;

  localparam logic [ADDR_WIDTH:0] DEPTH_L =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_L =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    INIT,
    ACTIVE
  } state_e;

  // Backdoor-visible storage; untouched by rst_n.
  logic [DW-1:0] mem [0:DEPTH-1];

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [DW-1:0]         rdata_q;
  logic                  rd_valid_q;
  logic                  ready_q;
  logic                  err_q;

  logic in_range_d;
  logic active_d;
  logic sweep_we_d;

  assign in_range_d = ({1'b0, addr} < DEPTH_L);
  assign active_d   = (state_q == ACTIVE);
  // Edges seen while rst_n is held low must not write.
  assign sweep_we_d = (state_q == INIT) &&
                      (CLEAR_ON_RESET != 0) && rst_n;

  // Storage writes: init sweep or lane-masked front-door write.
  always_ff @(posedge clk) begin
    if (sweep_we_d) begin
      mem[cnt_q] <= {MEM_NUMBER{INIT_VALUE}};
    end else if (active_d && wr_en && in_range_d) begin
      for (int k = 0; k < MEM_NUMBER; k++) begin
        if (lane_en[k]) begin
          mem[addr][k*WIDTH +: WIDTH] <=
            wdata[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Control FSM with registered read data and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        INIT: begin
          if (CLEAR_ON_RESET == 0 || cnt_q == LAST_L) begin
            state_q <= ACTIVE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_WIDTH'(1);
          end
        end
        ACTIVE: begin
          rd_valid_q <= rd_en;
          err_q      <= (rd_en | wr_en) & ~in_range_d;
          // Read-first: the old word is sampled at the write edge.
          if (rd_en) begin
            rdata_q <= in_range_d ? mem[addr] : '0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
  assign ready    = ready_q;
  assign err      = err_q;

endmodule

// File: tb/tb_banked_memory_wrapper.sv
// Directed bench for banked_memory_wrapper: three instances
// (default, shallow DEPTH=100, no-clear) share one stimulus bus.
module tb_banked_memory_wrapper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  addr;
  logic [31:0] wdata;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  lane_en;

  logic [31:0] rdata0, rdata1, rdata2;
  logic        v0, v1, v2;
  logic        rdy0, rdy1, rdy2;
  logic        err0, err1, err2;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] sbq [$];
  logic [31:0] snap [100];
  int          diffs;

  always #5 clk = ~clk;

  banked_memory_wrapper #(
    .INIT_VALUE(8'hA5)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
    .wr_en(wr_en), .lane_en(lane_en), .rd_en(rd_en),
    .rdata(rdata0), .rd_valid(v0), .ready(rdy0), .err(err0)
  );

  banked_memory_wrapper #(
    .DEPTH(100), .INIT_VALUE(8'hA5)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
    .wr_en(wr_en), .lane_en(lane_en), .rd_en(rd_en),
    .rdata(rdata1), .rd_valid(v1), .ready(rdy1), .err(err1)
  );

  banked_memory_wrapper #(
    .CLEAR_ON_RESET(0), .INIT_VALUE(8'hA5)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
    .wr_en(wr_en), .lane_en(lane_en), .rd_en(rd_en),
    .rdata(rdata2), .rd_valid(v2), .ready(rdy2), .err(err2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a,
                    input logic [31:0] d,
                    input logic [3:0] le);
    addr = a; wdata = d; lane_en = le; wr_en = 1'b1;
    edge1();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a,
                    input logic [31:0] e);
    addr = a; rd_en = 1'b1;
    sbq.push_back(e);
    edge1();
    rd_en = 1'b0;
    chk("rd_lat", 32'(v0), 32'd1);
  endtask

  // Scoreboard: every rd_valid on u0 consumes one expectation.
  always @(negedge clk) begin
    if (v0 === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("rdv_spurious", 32'(v0), 32'd0);
      end else begin
        chk("rd_data", rdata0, sbq.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; addr = '0; wdata = '0;
    wr_en = 1'b0; rd_en = 1'b0; lane_en = '0;
    repeat (3) edge1();
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_rdv", 32'(v0), 32'd0);
    chk("rst_rdata", rdata0, 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_ready_u1", 32'(rdy1), 32'd0);

    // Sweep with requests held active; they must be ignored.
    rst_n = 1'b1;
    addr = 7'd3; wdata = 32'h12345678; lane_en = 4'hF;
    wr_en = 1'b1; rd_en = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      edge1();
      chk("sweep_ready", 32'(rdy0), 32'(k == 128));
      chk("sweep_rdv", 32'(v0), 32'd0);
      chk("sweep_err", 32'(err0), 32'd0);
      chk("u1_ready", 32'(rdy1), 32'(k >= 100));
      if (k == 90) begin
        wr_en = 1'b0;
        rd_en = 1'b0;
      end
    end
    chk("bd_mem3", u0.mem[3], 32'hA5A5A5A5);
    rd(7'd0, 32'hA5A5A5A5);
    rd(7'd64, 32'hA5A5A5A5);
    rd(7'd127, 32'hA5A5A5A5);
    rd(7'd3, 32'hA5A5A5A5);

    // Lane mask.
    wr(7'd5, 32'h11223344, 4'b1111);
    wr(7'd5, 32'hFFFFFFFF, 4'b0101);
    rd(7'd5, 32'h11FF33FF);
    wr(7'd6, 32'h01020304, 4'b0000);
    rd(7'd6, 32'hA5A5A5A5);

    // Read-first collision.
    wr(7'd9, 32'hDEADBEEF, 4'hF);
    addr = 7'd9; wdata = 32'h0; lane_en = 4'hF;
    wr_en = 1'b1; rd_en = 1'b1;
    sbq.push_back(32'hDEADBEEF);
    edge1();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("coll_lat", 32'(v0), 32'd1);
    rd(7'd9, 32'h0);

    // Back-to-back reads, then valid drops and data holds.
    addr = 7'd0; rd_en = 1'b1;
    sbq.push_back(32'hA5A5A5A5);
    edge1();
    chk("b2b_v1", 32'(v0), 32'd1);
    addr = 7'd5;
    sbq.push_back(32'h11FF33FF);
    edge1();
    chk("b2b_v2", 32'(v0), 32'd1);
    rd_en = 1'b0;
    edge1();
    chk("rdv_drop", 32'(v0), 32'd0);
    chk("rdata_hold", rdata0, 32'h11FF33FF);
    chk("sb_drain", 32'(sbq.size()), 32'd0);

    // Content for the no-clear instance to keep across reset.
    wr(7'd20, 32'hCAFEF00D, 4'hF);

    // Out of range on the DEPTH=100 instance.
    for (int i = 0; i < 100; i++) snap[i] = u1.mem[i];
    wr(7'd110, 32'h55AA55AA, 4'hF);
    chk("oor_wr_err", 32'(err1), 32'd1);
    chk("inr_wr_err", 32'(err0), 32'd0);
    edge1();
    chk("oor_err_drop", 32'(err1), 32'd0);
    rd(7'd110, 32'h55AA55AA);
    chk("oor_rd_v", 32'(v1), 32'd1);
    chk("oor_rd_data", rdata1, 32'd0);
    chk("oor_rd_err", 32'(err1), 32'd1);
    diffs = 0;
    for (int i = 0; i < 100; i++)
      if (u1.mem[i] !== snap[i]) diffs++;
    chk("oor_mem", 32'(diffs), 32'd0);

    // Reset clears pending valid/err at once.
    addr = 7'd110; rd_en = 1'b1;
    edge1();
    rd_en = 1'b0;
    chk("pend_v0", 32'(v0), 32'd1);
    chk("pend_err1", 32'(err1), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_v0", 32'(v0), 32'd0);
    chk("ar_ready", 32'(rdy0), 32'd0);
    chk("ar_err1", 32'(err1), 32'd0);
    chk("ar_v1", 32'(v1), 32'd0);
    chk("ar_rdata", rdata0, 32'd0);
    edge1();
    edge1();

    // Abort sweep at edge 50, then full restart.
    rst_n = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      edge1();
      if (k == 1) chk("u2_ready", 32'(rdy2), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_ready", 32'(rdy0), 32'd0);
    edge1();
    rst_n = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      edge1();
      chk("resweep_ready", 32'(rdy0), 32'(k == 128));
    end

    // u0 was re-swept; u2 kept its contents.
    rd(7'd20, 32'hA5A5A5A5);
    chk("keep20", rdata2, 32'hCAFEF00D);
    chk("keep20_v", 32'(v2), 32'd1);
    rd(7'd3, 32'hA5A5A5A5);
    chk("keep3", rdata2, 32'h12345678);
    rd(7'd5, 32'hA5A5A5A5);
    chk("keep5", rdata2, 32'h11FF33FF);
    rd(7'd9, 32'hA5A5A5A5);
    chk("keep9", rdata2, 32'h0);

    edge1();
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/banked_memory_wrapper.md
Name: banked_memory_wrapper

Overview:
- Parametrised successor of the single-port memory wrapper.
- MEM_NUMBER lanes of WIDTH bits share one address, with per-lane write enables and a registered read that carries a valid flag.
- A hardware init sweep loads every location after reset; a ready handshake gates accesses until the sweep completes.
- Storage stays one backdoor-visible array so benches keep file-based preload and dump of contents.

Parameters:
WIDTH, 8, bits per lane
DEPTH, 128, number of addressable words (1..2**ADDR_WIDTH)
ADDR_WIDTH, 7, address bits
MEM_NUMBER, 4, number of lanes; word width = WIDTH*MEM_NUMBER
CLEAR_ON_RESET, 1, 1 = run the init sweep after reset; 0 = skip it
INIT_VALUE, 0, WIDTH-bit value written to every lane during the sweep

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
addr  input  ADDR_WIDTH  word address for read and write
wdata  input  WIDTH*MEM_NUMBER  write data; lane k = bits [k*WIDTH +: WIDTH]
wr_en  input  1  write request
lane_en  input  MEM_NUMBER  per-lane write mask; bit k enables lane k
rd_en  input  1  read request
rdata  output  WIDTH*MEM_NUMBER  registered read data
rd_valid  output  1  one-cycle pulse: rdata holds a new read result
ready  output  1  high when requests are accepted
err  output  1  one-cycle pulse on an out-of-range access

Behaviour:
- Storage: array mem[0:DEPTH-1] of WIDTH*MEM_NUMBER bits. It is not cleared by rst_n; only the sweep writes it.
- Reset (rst_n low, asynchronous): rdata = 0, rd_valid = 0, ready = 0, err = 0, init counter = 0, FSM enters INIT.
- FSM has two states: INIT and ACTIVE.
- INIT with CLEAR_ON_RESET=1:
  - The k-th rising edge after rst_n deasserts (k = 1..DEPTH) writes {MEM_NUMBER{INIT_VALUE}} to mem[k-1].
  - At edge DEPTH the FSM moves to ACTIVE and ready goes 1.
- INIT with CLEAR_ON_RESET=0: edge 1 moves to ACTIVE with ready = 1, and memory is left untouched.
- During INIT, wr_en, rd_en and lane_en are ignored: no write, no rd_valid, no err.
- ACTIVE writes: wr_en=1 at an edge updates only the lanes whose lane_en bit is 1. Other lanes keep their contents. lane_en = 0 means no write.
- ACTIVE reads:
  - rd_en=1 at edge N sets rdata = mem[addr] and rd_valid = 1 after edge N (latency 1).
  - rd_valid drops after the next edge unless rd_en is held. Back-to-back reads give one result per cycle.
  - rdata holds its last value while rd_valid = 0.
- Simultaneous read and write to the same address: read-first. rdata returns the pre-write contents; the write lands at the same edge.
- Out of range (addr >= DEPTH, only possible when DEPTH < 2**ADDR_WIDTH):
  - Writes are dropped.
  - Reads set rdata = 0 with rd_valid = 1.
  - err = 1 for one cycle after any such request edge.
- Reset mid-operation:
  - A sweep in progress is aborted and restarts from address 0 after rst_n releases.
  - Any pending rd_valid or err is cleared immediately.
- ready stays 1 in ACTIVE until the next reset. There is no back-pressure in ACTIVE.

Test Plan:
- Init sweep, defaults (INIT_VALUE=8'hA5): release rst_n → ready=0 for 127 edges, ready=1 after edge 128. Reads of addr 0, 64 and 127 return 32'hA5A5A5A5 with rd_valid one cycle after each rd_en edge.
- Lane mask: write addr 5, wdata=32'h11223344, lane_en=4'b1111. Then write addr 5, wdata=32'hFFFFFFFF, lane_en=4'b0101. Read addr 5 → 32'h11FF33FF.
- Read-first collision: mem[9]=32'hDEADBEEF. Same edge: wr_en=1, rd_en=1, addr=9, wdata=32'h0, lane_en=4'hF. rdata=32'hDEADBEEF; the next read of addr 9 gives 32'h0.
- Gated during init: issue wr_en at addr 3 (32'h12345678) and rd_en while ready=0 → no rd_valid. After ready, mem[3] = INIT pattern.
- Out of range, DEPTH=100, ADDR_WIDTH=7: write addr 110, then read addr 110 → err pulses on both. Read gives rdata=0 with rd_valid=1, and mem[0..99] is unchanged.
- Reset mid-sweep and backdoor: drop rst_n at edge 50 of the sweep → ready=0 and rd_valid=0 immediately, and the sweep completes 128 edges after release. With CLEAR_ON_RESET=0, a file preload of mem survives reset and front-door reads match the file.
